wb_reg_slice: RTL
=================

Name: wb_reg_slice

Overview:
- Parametrised Wishbone register slice inserted between an interconnect master port and a slave port to break timing paths.
- Registers the request path unconditionally; the response path is registered or bypassed via RSP_REG.
- Adds a per-transaction timeout with error response, and abort handling when the master drops cyc mid-transfer.
- One outstanding transaction at a time; placed in the wb_interconnect per slave port.

Parameters:
DW, 32, data bus width in bits
AW, 32, address bus width in bits
TW, 2, transaction-id width in bits (>=1)
RSP_REG, 1, 1 = registered response (one extra cycle), 0 = combinational response bypass
TIMEOUT, 255, slave cycles allowed before forced error; 0 disables the timeout

Ports:
clk_i  in  1  clock
rst_n  in  1  asynchronous active-low reset
m_wb_dat_i  in  DW  master write data
m_wb_adr_i  in  AW  master address
m_wb_sel_i  in  DW/8  master byte selects
m_wb_we_i  in  1  master write enable
m_wb_cyc_i  in  1  master cycle
m_wb_stb_i  in  1  master strobe
m_wb_tid_i  in  TW  master transaction id
m_wb_dat_o  out  DW  read data to master
m_wb_ack_o  out  1  ack to master
m_wb_err_o  out  1  error to master
s_wb_dat_i  in  DW  slave read data
s_wb_ack_i  in  1  slave ack
s_wb_err_i  in  1  slave error
s_wb_dat_o, s_wb_adr_o, s_wb_sel_o, s_wb_we_o, s_wb_cyc_o, s_wb_stb_o, s_wb_tid_o  out  DW/AW/DW8/1/1/1/TW  registered request to slave
busy_o  out  1  transaction in flight (state != IDLE)
timeout_o  out  1  one-cycle pulse when a timeout fires

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE; every s_wb_* output 0; m_wb_dat_o/ack/err 0; busy_o=0; timeout_o=0; timeout counter 0; abort flag 0. Any in-flight transfer is discarded.
- FSM states:
  - IDLE: on clock edge with m_stb&m_cyc, capture dat/adr/sel/we/tid, set s_cyc=s_stb=1, clear counter and abort flag, go to REQ. No capture otherwise.
  - REQ: s_cyc/s_stb held high with stable request fields. Counter increments each cycle while neither s_ack nor s_err is high.
    - If m_cyc_i goes low, set the abort flag. The slave transfer still completes; its response is suppressed.
    - On s_ack|s_err: clear all s_wb_* outputs to 0 at that edge. If RSP_REG=1, go to RSP; if RSP_REG=0, go to IDLE.
    - Timeout: TIMEOUT!=0, counter==TIMEOUT-1 and no s_ack/s_err. Clear s_wb_* outputs, pulse timeout_o for one cycle, go to RSP carrying an error.
    - Slave ack/err wins over a timeout in the same cycle.
  - RSP (always used for timeout; for RSP_REG=1 also used for normal completion): one cycle.
    - m_ack_o/m_err_o/m_dat_o driven from the values registered at the completion edge. On timeout: ack=0, err=1, dat=0.
    - Then go to IDLE. RSP never captures a new request, which prevents re-capture of a strobe still held high.
- Response path, RSP_REG=0: in REQ, m_ack_o=s_ack_i&~abort, m_err_o=s_err_i&~abort, m_dat_o=s_dat_i (combinational). m_dat_o=0 outside REQ, except the timeout error cycle in RSP.
- Response path, RSP_REG=1: m_ack_o/m_err_o are high only in RSP, and only if abort=0. m_dat_o is 0 except in an ack RSP cycle.
- If s_ack_i and s_err_i are both high, the transfer completes with err; ack is not forwarded.
- Latency, master stb to m_ack: 2 cycles minimum with RSP_REG=0, 3 cycles with RSP_REG=1, each with a zero-wait-state slave.
- Back-to-back: a new request is capturable in the first IDLE cycle. Throughput is 1 transfer per 2 cycles (RSP_REG=0) or 3 cycles (RSP_REG=1).
- s_ack_i/s_err_i arriving in IDLE or RSP are ignored.
- Counter width is $clog2(TIMEOUT+1) and saturates; it is never compared when TIMEOUT=0.

Test Plan:
- Default params; read adr=0x3000_0010, slave acks in 1 cycle with dat=0xDEAD_BEEF -> s_stb high 1 cycle after m_stb; m_ack high 3 cycles after m_stb with m_dat=0xDEAD_BEEF; s_wb_* all 0 the cycle after s_ack.
- RSP_REG=0; write dat=0x1234_5678, sel=4'b0011, tid=2 -> s_wb outputs carry exactly those values; m_ack is coincident with s_ack; a new request captured the following cycle reaches s_stb 1 cycle later.
- TIMEOUT=4, slave never responds -> s_stb high for exactly 4 cycles, then drops; timeout_o pulses once; next cycle m_err=1, m_ack=0, m_dat=0; busy_o returns to 0.
- Master drops m_cyc 1 cycle after issue, slave acks 3 cycles later -> s_stb held until the slave ack; m_ack and m_err stay 0 throughout.
- Slave asserts ack and err together -> m_err=1, m_ack=0; timeout coincident with s_ack (TIMEOUT=3, ack on the 3rd cycle) -> m_ack=1, timeout_o=0.
- rst_n pulsed low mid-REQ -> all outputs 0 asynchronously; after release the block is IDLE and the next request completes normally.

Source files
------------

// File: rtl/wb_reg_slice.sv
// Wishbone register slice for one slave port of the interconnect.
// The request path is always registered. The response path is either
// registered (RSP_REG=1) or passed straight through (RSP_REG=0).
// Only one transaction is in flight at a time. A stalled slave is
// cut off by a per-transaction timeout, which returns an error to the
// master. If the master drops cyc mid-transfer, the slave transfer
// still finishes, but its response is suppressed.
module wb_reg_slice #(
  parameter int DW      = 32,
  parameter int AW      = 32,
  parameter int TW      = 2,
  parameter int RSP_REG = 1,
  parameter int TIMEOUT = 255
) (
  input  logic            clk_i,
  input  logic            rst_n,
  input  logic [DW-1:0]   m_wb_dat_i,
  input  logic [AW-1:0]   m_wb_adr_i,
  input  logic [DW/8-1:0] m_wb_sel_i,
  input  logic            m_wb_we_i,
  input  logic            m_wb_cyc_i,
  input  logic            m_wb_stb_i,
  input  logic [TW-1:0]   m_wb_tid_i,
  output logic [DW-1:0]   m_wb_dat_o,
  output logic            m_wb_ack_o,
  output logic            m_wb_err_o,
  input  logic [DW-1:0]   s_wb_dat_i,
  input  logic            s_wb_ack_i,
  input  logic            s_wb_err_i,
  output logic [DW-1:0]   s_wb_dat_o,
  output logic [AW-1:0]   s_wb_adr_o,
  output logic [DW/8-1:0] s_wb_sel_o,
  output logic            s_wb_we_o,
  output logic            s_wb_cyc_o,
  output logic            s_wb_stb_o,
  output logic [TW-1:0]   s_wb_tid_o,
  output logic            busy_o,
  output logic            timeout_o
);

  // The counter is kept at least one bit wide so that TIMEOUT=0 still
  // elaborates. In that case the counter is never compared.
  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] TO_LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RSP  = 2'd2
  } state_t;

  state_t          state_reg;
  logic [CW-1:0]   cnt_reg;
  logic            abort_reg;
  logic            rsp_ack_reg;
  logic            rsp_err_reg;
  logic [DW-1:0]   rsp_dat_reg;

  logic            slave_done;
  logic            slave_ack_only;
  logic            abort_next;
  logic            timeout_hit;

  assign slave_done     = s_wb_ack_i | s_wb_err_i;
  // An error wins when the slave raises ack and err together.
  assign slave_ack_only = s_wb_ack_i & ~s_wb_err_i;
  // Abort state as it will be after this edge. This lets a cyc drop
  // that lands on the completion edge still suppress the registered
  // response.
  assign abort_next     = abort_reg | ~m_wb_cyc_i;

  generate
    if (TIMEOUT > 0) begin : g_timeout
      assign timeout_hit = (cnt_reg == TO_LAST);
    end else begin : g_no_timeout
      assign timeout_hit = 1'b0;
    end
  endgenerate

  // Transaction FSM: capture the request, hold it toward the slave,
  // then complete through the optional response cycle.
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= IDLE;
      cnt_reg     <= '0;
      abort_reg   <= 1'b0;
      rsp_ack_reg <= 1'b0;
      rsp_err_reg <= 1'b0;
      rsp_dat_reg <= '0;
      s_wb_dat_o  <= '0;
      s_wb_adr_o  <= '0;
      s_wb_sel_o  <= '0;
      s_wb_we_o   <= 1'b0;
      s_wb_cyc_o  <= 1'b0;
      s_wb_stb_o  <= 1'b0;
      s_wb_tid_o  <= '0;
      timeout_o   <= 1'b0;
    end else begin
      timeout_o <= 1'b0;
      case (state_reg)
        IDLE: begin
          rsp_ack_reg <= 1'b0;
          rsp_err_reg <= 1'b0;
          rsp_dat_reg <= '0;
          if (m_wb_stb_i && m_wb_cyc_i) begin
            s_wb_dat_o <= m_wb_dat_i;
            s_wb_adr_o <= m_wb_adr_i;
            s_wb_sel_o <= m_wb_sel_i;
            s_wb_we_o  <= m_wb_we_i;
            s_wb_tid_o <= m_wb_tid_i;
            s_wb_cyc_o <= 1'b1;
            s_wb_stb_o <= 1'b1;
            cnt_reg    <= '0;
            abort_reg  <= 1'b0;
            state_reg  <= REQ;
          end
        end

        REQ: begin
          if (!m_wb_cyc_i) begin
            abort_reg <= 1'b1;
          end
          if (slave_done) begin
            // A slave response takes priority over a timeout on the same edge.
            s_wb_dat_o <= '0;
            s_wb_adr_o <= '0;
            s_wb_sel_o <= '0;
            s_wb_we_o  <= 1'b0;
            s_wb_cyc_o <= 1'b0;
            s_wb_stb_o <= 1'b0;
            s_wb_tid_o <= '0;
            if (RSP_REG != 0) begin
              rsp_ack_reg <= slave_ack_only & ~abort_next;
              rsp_err_reg <= s_wb_err_i & ~abort_next;
              rsp_dat_reg <= (slave_ack_only && !abort_next) ? s_wb_dat_i : '0;
              state_reg   <= RSP;
            end else begin
              state_reg   <= IDLE;
            end
          end else if (timeout_hit) begin
            s_wb_dat_o  <= '0;
            s_wb_adr_o  <= '0;
            s_wb_sel_o  <= '0;
            s_wb_we_o   <= 1'b0;
            s_wb_cyc_o  <= 1'b0;
            s_wb_stb_o  <= 1'b0;
            s_wb_tid_o  <= '0;
            timeout_o   <= 1'b1;
            rsp_ack_reg <= 1'b0;
            rsp_err_reg <= ~abort_next;
            rsp_dat_reg <= '0;
            state_reg   <= RSP;
          end else if (cnt_reg != {CW{1'b1}}) begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end

        RSP: begin
          // Never capture here. A strobe still held from the finished
          // transfer must not start a second one.
          rsp_ack_reg <= 1'b0;
          rsp_err_reg <= 1'b0;
          rsp_dat_reg <= '0;
          state_reg   <= IDLE;
        end

        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

  // Response mux: straight from the slave while in REQ when unregistered,
  // otherwise from the response registers, which are zero outside RSP.
  always_comb begin
    m_wb_ack_o = rsp_ack_reg;
    m_wb_err_o = rsp_err_reg;
    m_wb_dat_o = rsp_dat_reg;
    if (RSP_REG == 0 && state_reg == REQ) begin
      m_wb_ack_o = slave_ack_only & ~abort_reg;
      m_wb_err_o = s_wb_err_i & ~abort_reg;
      m_wb_dat_o = s_wb_dat_i;
    end
  end

  assign busy_o = (state_reg != IDLE);

endmodule
